tt_um_example_multiplier: RTL and testbench
===========================================

Name: tt_um_example_multiplier

Overview:
Tiny Tapeout user tile implementing a 4x4 unsigned array multiplier with a registered 8-bit product.
- Operands come in on the dedicated input bus ui_in; the product drives uo_out.
- The bidirectional bus is unused and held as input.
- Sits directly under the tile harness as the project top-level.

Parameters:
REGISTER_OUTPUT, 1, 1 = product captured in an output register (1-cycle latency); 0 = uo_out driven combinationally from the array (reset and ena then have no effect on uo_out).

Ports:
clk      input   1  tile clock; the single clock domain
rst_n    input   1  reset, asynchronous, active-low
ena      input   1  tile enable, high when the design is selected
ui_in    input   8  [3:0] = operand A, [7:4] = operand B, both unsigned
uo_out   output  8  unsigned product A*B
uio_in   input   8  unused, ignored
uio_out  output  8  constant 8'h00
uio_oe   output  8  constant 8'h00 (all bidirectional pins are inputs)
VPWR/VGND exist only in gate-level netlists; they are not part of RTL.

Behaviour:
- Clocking and reset:
  - One clock, clk; everything is synchronous to its rising edge except reset.
  - Reset is asynchronous and active-low on rst_n.
  - While rst_n = 0, the product register = 8'h00, so uo_out = 8'h00.
  - Reset release takes effect at the next rising edge of clk.
- Array structure (REGISTER_OUTPUT-independent):
  - Partial products pp[i][j] = A[j] & B[i], for i, j in 0..3.
  - Rows are summed by a ripple array of full and half adders: row 0 = pp[0]; each following row adds pp[i] shifted left by i.
  - Final ripple produces P[7:0].
  - Written structurally (explicit FA/HA cells); no "*" operator.
  - Result is exact: P = A*B, range 0..225; no overflow is possible in 8 bits.
- Output register (REGISTER_OUTPUT = 1):
  - On each rising clk edge with rst_n = 1 and ena = 1: product register <= P.
  - With ena = 0: register holds its value.
  - uo_out = product register.
  - Latency is one cycle: ui_in set before edge N appears on uo_out after edge N.
  - A new operand pair is accepted every cycle; there is no handshake.
- Boundary conditions:
  - ui_in changing mid-cycle: only the value at the clock edge is captured.
  - Reset asserted mid-operation: uo_out goes to 0 immediately, without waiting for a clock edge.
  - The first capture after reset is the first rising edge with rst_n = 1 and ena = 1.
  - rst_n deasserting on the same edge as a capture: the capture is not guaranteed; the bench must not rely on it.
  - A = 0 or B = 0 -> 0. A = 15, B = 15 -> 225 (8'hE1).
- Unused inputs: uio_in (and ena, when REGISTER_OUTPUT = 0) must be referenced in a reduction to avoid lint warnings; they have no functional effect.

Test Plan:
1. rst_n = 0 with ui_in = 8'hFF, clock running -> uo_out = 8'h00. Release rst_n, one edge -> uo_out = 8'hE1.
2. ui_in = 8'h53 (A = 3, B = 5), ena = 1, one edge -> uo_out = 8'h0F. Then ui_in = 8'h7C (A = 12, B = 7) -> 8'h54 after the next edge.
3. ui_in = 8'hF0 then 8'h0F (one operand zero) -> uo_out = 8'h00 after each edge. ui_in = 8'h11 -> 8'h01.
4. Enable hold: capture 8'h53 -> 8'h0F; set ena = 0 and ui_in = 8'hFF for 3 edges -> uo_out stays 8'h0F. Set ena = 1 -> 8'hE1 after one edge.
5. Reset mid-operation: uo_out = 8'hE1, pulse rst_n low between edges -> uo_out = 8'h00 asynchronously, held until the first enabled edge after release.
6. Exhaustive sweep of all 256 ui_in values, each checked one cycle later: uo_out == ui_in[3:0] * ui_in[7:4]. uio_out and uio_oe == 8'h00 throughout.

Source files
------------

// File: rtl/tt_um_example_multiplier.sv
// Tiny Tapeout tile: 4x4 unsigned array multiplier built from explicit
// half/full adder cells, with an optional registered 8-bit product.

module tt_um_example_multiplier_ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module tt_um_example_multiplier_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module tt_um_example_multiplier #(
  parameter int REGISTER_OUTPUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] pp_s  [0:3];
  logic [3:0] x_s   [1:3];
  logic [3:0] sum_s [1:3];
  logic [3:0] cy_s  [1:3];
  logic [7:0] p_s;

  assign a_s = ui_in[3:0];
  assign b_s = ui_in[7:4];

  // Partial products: row i holds A gated by B[i].
  for (genvar i = 0; i < 4; i++) begin : g_pp
    for (genvar j = 0; j < 4; j++) begin : g_bit
      assign pp_s[i][j] = a_s[j] & b_s[i];
    end
  end

  // Each adder row sees the running sum shifted right by one; the dropped
  // LSB is already a final product bit.
  assign x_s[1] = {1'b0, pp_s[0][3:1]};
  assign x_s[2] = {cy_s[1][3], sum_s[1][3:1]};
  assign x_s[3] = {cy_s[2][3], sum_s[2][3:1]};

  for (genvar i = 1; i < 4; i++) begin : g_row
    tt_um_example_multiplier_ha u_ha (
      .a     (x_s[i][0]),
      .b     (pp_s[i][0]),
      .sum   (sum_s[i][0]),
      .carry (cy_s[i][0])
    );
    for (genvar j = 1; j < 4; j++) begin : g_fa
      tt_um_example_multiplier_fa u_fa (
        .a     (x_s[i][j]),
        .b     (pp_s[i][j]),
        .cin   (cy_s[i][j-1]),
        .sum   (sum_s[i][j]),
        .carry (cy_s[i][j])
      );
    end
  end

  assign p_s = {cy_s[3][3], sum_s[3], sum_s[2][0], sum_s[1][0], pp_s[0][0]};

  if (REGISTER_OUTPUT != 0) begin : g_reg
    logic [7:0] prod_r;

    // Product register: captures the array result on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_r <= 8'h00;
      end else if (ena) begin
        prod_r <= p_s;
      end else begin
        prod_r <= prod_r;
      end
    end

    assign uo_out = prod_r;
  end else begin : g_comb
    assign uo_out = p_s;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_s;
  assign unused_s = &{1'b0, uio_in, ena};

endmodule

// File: tb/tb_tt_um_example_multiplier.sv
// Self-checking bench for tt_um_example_multiplier: directed cases, exhaustive
// sweep and randomized traffic against a cycle-level product model.

module tb_tt_um_example_multiplier;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int model_q    = 0;

  tt_um_example_multiplier #(.REGISTER_OUTPUT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: register holds A*B of the last enabled, out-of-reset edge.
  task automatic step();
    @(posedge clk);
    if (rst_n && ena) model_q = int'(ui_in[3:0]) * int'(ui_in[7:4]);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic en);
    @(negedge clk);
    ui_in  = v;
    ena    = en;
    uio_in = 8'($urandom);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h00;

    // 1: reset holds zero, release captures 15*15
    repeat (3) step();
    check_val("reset_zero", uo_out, 0);
    check_val("reset_uio_out", uio_out, 0);
    check_val("reset_uio_oe", uio_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_val("release_ff", uo_out, 225);

    // 2: basic products
    drive(8'h53, 1'b1); step(); check_val("mul_3x5", uo_out, 15);
    drive(8'h7C, 1'b1); step(); check_val("mul_12x7", uo_out, 84);

    // 3: zero operands and 1x1
    drive(8'hF0, 1'b1); step(); check_val("a_zero", uo_out, 0);
    drive(8'h0F, 1'b1); step(); check_val("b_zero", uo_out, 0);
    drive(8'h11, 1'b1); step(); check_val("one_x_one", uo_out, 1);

    // 4: enable hold
    drive(8'h53, 1'b1); step(); check_val("hold_pre", uo_out, 15);
    drive(8'hFF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("hold_ena0", uo_out, 15);
    end
    drive(8'hFF, 1'b1); step(); check_val("hold_resume", uo_out, 225);

    // 5: asynchronous reset mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_q = 0;
    check_val("async_reset", uo_out, 0);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_val("after_rel_ena0", uo_out, 0);
    drive(8'hFF, 1'b1); step(); check_val("first_enabled", uo_out, 225);

    // 6: exhaustive sweep, product checked one cycle later
    for (int v = 0; v < 256; v++) begin
      drive(8'(v), 1'b1);
      #2 ui_in = 8'(v);
      step();
      check_val("sweep", uo_out, (v % 16) * (v / 16));
      check_val("sweep_uio_out", uio_out, 0);
      check_val("sweep_uio_oe", uio_oe, 0);
    end

    // Randomized traffic with random enable and mid-cycle glitches on ui_in
    for (int n = 0; n < 400; n++) begin
      logic [7:0] v;
      logic       en;
      v  = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ui_in  = 8'($urandom);
      ena    = en;
      uio_in = 8'($urandom);
      #2 ui_in = v;
      step();
      check_val("random", uo_out, model_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
